// File: rtl/uart_pkg.sv
// uart_pkg: UART register map, debug-frame constants and dump FSM state encoding.
// Defining UART_DUMP_CHECKSUM_EN adds a trailing XOR checksum byte to the frame.
package uart_pkg;
    typedef enum logic [2:0] {
        REG_TX_DATA = 3'd0,
        REG_TX_DONE = 3'd1,
        REG_TX_RDY  = 3'd2,
        REG_RX_DATA = 3'd3,
        REG_RX_DONE = 3'd4
    } uart_reg_t;

    localparam logic [7:0] FRAME_HDR = 8'hA5;

`ifdef UART_DUMP_CHECKSUM_EN
    localparam int CSUM_BYTES = 1;
`else
    localparam int CSUM_BYTES = 0;
`endif

    typedef enum logic [2:0] {
        ST_IDLE, ST_WR_DATA, ST_WR_RDY, ST_RD_DONE,
        ST_CHK_DONE, ST_CLR_DONE, ST_CLR_RDY, ST_NEXT
    } state_t;

    // header + PC(2) + counter + acc(2) + optional checksum
    function automatic int frame_len(input int cnt_w);
        return 5 + cnt_w / 8 + CSUM_BYTES;
    endfunction
endpackage

// File: rtl/dump_byte_mux.sv
// dump_byte_mux: selects debug-frame byte idx from the frozen snapshot.
// Appends the XOR checksum byte when UART_DUMP_CHECKSUM_EN is defined.
module dump_byte_mux
    import uart_pkg::*;
#(
    parameter int CNT_W  = 32,
    parameter int NBYTES = frame_len(CNT_W),
    parameter int IW     = $clog2(NBYTES)
) (
    input  logic [15:0]      pc,
    input  logic [CNT_W-1:0] cnt,
    input  logic [15:0]      acc,
    input  logic [IW-1:0]    idx,
    output logic [7:0]       data
);
    localparam int NB = 5 + CNT_W / 8;

    logic [NB*8-1:0]     body;
    logic [NBYTES*8-1:0] frame;

    // Byte 0 sits in the low lane so fields go out LSB first.
    assign body = {acc, cnt, pc, FRAME_HDR};

`ifdef UART_DUMP_CHECKSUM_EN
    logic [7:0] csum;
    always_comb begin
        csum = '0;
        for (int i = 0; i < NB; i++) csum = csum ^ body[i*8 +: 8];
    end
    assign frame = {csum, body};
`else
    assign frame = body;
`endif

    always_comb begin
        data = '0;
        for (int i = 0; i < NBYTES; i++) data = (idx == IW'(i)) ? frame[i*8 +: 8] : data;
    end
endmodule

// File: rtl/uart_dump_ctrl.sv
// uart_dump_ctrl: takes the UART bus from the CPU and sends a PC/counter/acc debug frame.
// Defining UART_DUMP_CHECKSUM_EN appends an XOR checksum byte to each frame.
module uart_dump_ctrl
    import uart_pkg::*;
#(
    parameter int NB_PC          = 11,
    parameter int DATA_BUS_WIDTH = 16,
    parameter int ADDR_BUS_WIDTH = 11,
    parameter int CNT_W          = 32,
    parameter int POLL_LIMIT     = 65535
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_start,
    input  logic                      i_cpu_en,
    input  logic                      i_cnt_clr,
    input  logic [NB_PC-1:0]          i_pc,
    input  logic [DATA_BUS_WIDTH-1:0] i_acc,
    output logic                      o_cs,
    output logic                      o_w_r,
    output logic [ADDR_BUS_WIDTH-1:0] o_addr,
    output logic [DATA_BUS_WIDTH-1:0] o_wdata,
    input  logic [DATA_BUS_WIDTH-1:0] i_rdata,
    output logic                      o_cpu_grant,
    output logic                      o_busy,
    output logic                      o_done,
    output logic                      o_err
);
    localparam int NBYTES = frame_len(CNT_W);
    localparam int IW     = $clog2(NBYTES);
    localparam int PW     = $clog2(POLL_LIMIT + 1);
    localparam logic [ADDR_BUS_WIDTH-1:0] A_TXD  = ADDR_BUS_WIDTH'(REG_TX_DATA);
    localparam logic [ADDR_BUS_WIDTH-1:0] A_DONE = ADDR_BUS_WIDTH'(REG_TX_DONE);
    localparam logic [ADDR_BUS_WIDTH-1:0] A_RDY  = ADDR_BUS_WIDTH'(REG_TX_RDY);
    localparam logic [DATA_BUS_WIDTH-1:0] D_ARM  = DATA_BUS_WIDTH'(1);

    state_t           state;
    logic [CNT_W-1:0] cnt, snap_cnt;
    logic [15:0]      snap_pc, snap_acc;
    logic [IW-1:0]    idx;
    logic [PW-1:0]    polls;
    logic             abort, fin, last;
    logic [7:0]       cur_byte;
    logic             unused_rdata;

    assign unused_rdata = ^i_rdata[DATA_BUS_WIDTH-1:1];
    assign last = idx == IW'(NBYTES - 1);

    dump_byte_mux #(.CNT_W(CNT_W), .NBYTES(NBYTES), .IW(IW)) u_mux (
        .pc(snap_pc), .cnt(snap_cnt), .acc(snap_acc), .idx(idx), .data(cur_byte)
    );

    always_ff @(posedge i_clk or negedge i_rst)
        if (!i_rst) cnt <= '0;
        else cnt <= i_cnt_clr ? '0 : cnt + CNT_W'(i_cpu_en);

    // Bus outputs are loaded on the same edge as the state they belong to.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state       <= ST_IDLE;
            o_cs        <= 1'b0;
            o_w_r       <= 1'b0;
            o_addr      <= '0;
            o_wdata     <= '0;
            o_cpu_grant <= 1'b1;
            o_busy      <= 1'b0;
            o_done      <= 1'b0;
            o_err       <= 1'b0;
            idx         <= '0;
            polls       <= '0;
            abort       <= 1'b0;
            fin         <= 1'b0;
            snap_pc     <= '0;
            snap_acc    <= '0;
            snap_cnt    <= '0;
        end else begin
            o_done <= 1'b0;
            case (state)
                ST_IDLE: if (i_start) begin
                    snap_pc     <= 16'(i_pc);
                    snap_acc    <= 16'(i_acc);
                    snap_cnt    <= cnt;
                    o_err       <= 1'b0;
                    idx         <= '0;
                    abort       <= 1'b0;
                    o_busy      <= 1'b1;
                    o_cpu_grant <= 1'b0;
                    o_cs        <= 1'b1;
                    o_w_r       <= 1'b1;
                    o_addr      <= A_TXD;
                    o_wdata     <= DATA_BUS_WIDTH'(FRAME_HDR);
                    state       <= ST_WR_DATA;
                end
                ST_WR_DATA: begin
                    o_addr  <= A_RDY;
                    o_wdata <= D_ARM;
                    state   <= ST_WR_RDY;
                end
                ST_WR_RDY: begin
                    o_w_r   <= 1'b0;
                    o_addr  <= A_DONE;
                    o_wdata <= '0;
                    state   <= ST_RD_DONE;
                end
                ST_RD_DONE: begin
                    polls <= '0;
                    state <= ST_CHK_DONE;
                end
                ST_CHK_DONE: if (i_rdata[0]) begin
                    o_w_r <= 1'b1;
                    state <= ST_CLR_DONE;
                end else if (polls == PW'(POLL_LIMIT - 1)) begin
                    o_err  <= 1'b1;
                    abort  <= 1'b1;
                    o_w_r  <= 1'b1;
                    o_addr <= A_RDY;
                    state  <= ST_CLR_RDY;
                end else begin
                    polls <= polls + PW'(1);
                end
                ST_CLR_DONE: begin
                    o_addr <= A_RDY;
                    state  <= ST_CLR_RDY;
                end
                ST_CLR_RDY: begin
                    fin     <= abort || last;
                    o_done  <= !abort && last;
                    idx     <= (abort || last) ? idx : idx + IW'(1);
                    o_cs    <= 1'b0;
                    o_w_r   <= 1'b0;
                    o_addr  <= '0;
                    o_wdata <= '0;
                    state   <= ST_NEXT;
                end
                ST_NEXT: if (fin) begin
                    o_busy      <= 1'b0;
                    o_cpu_grant <= 1'b1;
                    state       <= ST_IDLE;
                end else begin
                    o_cs    <= 1'b1;
                    o_w_r   <= 1'b1;
                    o_addr  <= A_TXD;
                    o_wdata <= DATA_BUS_WIDTH'(cur_byte);
                    state   <= ST_WR_DATA;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_dump_ctrl.sv
// tb_uart_dump_ctrl: directed vectors plus a small UART register model for uart_dump_ctrl.
// Honours UART_DUMP_CHECKSUM_EN to expect the trailing checksum byte.
module tb_uart_dump_ctrl;
`ifdef UART_DUMP_CHECKSUM_EN
    localparam int CS_B = 1;
`else
    localparam int CS_B = 0;
`endif
    localparam int NB  = 9 + CS_B;
    localparam int NB8 = 6 + CS_B;

    typedef struct {
        logic [10:0]     pc;
        logic [15:0]     acc;
        int              cyc;
        bit              clr;
        int              poll;
        logic [9:0][7:0] exp;
    } vec_t;

    logic        clk = 1'b0, rst_n = 1'b0;
    logic        start = 1'b0, cpu_en = 1'b0, cnt_clr = 1'b0;
    logic        start2 = 1'b0, en2 = 1'b0, clr2 = 1'b0;
    logic [10:0] pc = '0;
    logic [15:0] acc = '0;
    logic        cs, w_r, grant, busy, done, err;
    logic [10:0] addr;
    logic [15:0] wdata, rdata;
    logic        cs2, w_r2, grant2, busy2, done2, err2;
    logic [10:0] addr2;
    logic [15:0] wdata2, rdata2;

    int   n_chk = 0, n_fail = 0;
    int   done_after = 3, rd_cnt = 0, rd_cycles = 0, done_cnt = 0, done_cnt2 = 0;
    bit   armed = 1'b0;
    logic [7:0]  cap[$], cap2[$];
    logic [10:0] last_waddr = '0;
    logic [15:0] last_wdata = '0;

    always #5 clk = ~clk;

    uart_dump_ctrl #(.POLL_LIMIT(8)) dut (
        .i_clk(clk), .i_rst(rst_n), .i_start(start), .i_cpu_en(cpu_en), .i_cnt_clr(cnt_clr),
        .i_pc(pc), .i_acc(acc), .o_cs(cs), .o_w_r(w_r), .o_addr(addr), .o_wdata(wdata),
        .i_rdata(rdata), .o_cpu_grant(grant), .o_busy(busy), .o_done(done), .o_err(err)
    );

    uart_dump_ctrl #(.CNT_W(8)) dut8 (
        .i_clk(clk), .i_rst(rst_n), .i_start(start2), .i_cpu_en(en2), .i_cnt_clr(clr2),
        .i_pc(pc), .i_acc(acc), .o_cs(cs2), .o_w_r(w_r2), .o_addr(addr2), .o_wdata(wdata2),
        .i_rdata(rdata2), .o_cpu_grant(grant2), .o_busy(busy2), .o_done(done2), .o_err(err2)
    );

    // tx_done reads back 1 once done_after reads have been seen since TX was armed
    assign rdata  = {15'b0, cs && !w_r && addr == 11'd1 && armed && rd_cnt >= done_after};
    assign rdata2 = {15'b0, cs2 && !w_r2 && addr2 == 11'd1};

    always @(negedge clk) begin
        if (done) done_cnt++;
        if (done2) done_cnt2++;
        if (cs2 && w_r2 && addr2 == 11'd0) cap2.push_back(wdata2[7:0]);
        if (cs && w_r) begin
            last_waddr = addr;
            last_wdata = wdata;
            if (addr == 11'd0) cap.push_back(wdata[7:0]);
            if (addr == 11'd2 && wdata == 16'd1) begin
                armed  = 1'b1;
                rd_cnt = 0;
            end
            if (addr == 11'd1) armed = 1'b0;
        end
        if (cs && !w_r && addr == 11'd1) begin
            rd_cnt++;
            rd_cycles++;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, required completion before 2 ms");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] cap_at(input int i);
        return (i < cap.size()) ? cap[i] : 8'hxx;
    endfunction

    function automatic logic [7:0] cap2_at(input int i);
        return (i < cap2.size()) ? cap2[i] : 8'hxx;
    endfunction

    task automatic start_frame();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    task automatic wait_idle(input bit sel, input string tag);
        int n = 0;
        while ((sel ? busy2 : busy) && n < 5000) begin
            @(negedge clk);
            n++;
        end
        check(tag, sel ? busy2 : busy, 0);
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (!done && n < 5000) begin
            @(negedge clk);
            n++;
        end
        check(tag, done, 1);
    endtask

    task automatic frame8(input logic [7:0] exp_cnt, input string tag);
        int b = cap2.size(), d0 = done_cnt2;
        @(negedge clk) start2 = 1'b1;
        @(negedge clk) start2 = 1'b0;
        wait_idle(1, {tag, "_idle"});
        check({tag, "_nbytes"}, cap2.size() - b, NB8);
        check({tag, "_cnt_byte"}, cap2_at(b + 3), exp_cnt);
        check({tag, "_done"}, done_cnt2 - d0, 1);
    endtask

    vec_t vecs[3];
    logic [9:0][7:0] frozen;
    int base, d0, r0;

    initial begin
        vecs[0] = '{11'h000, 16'h1234, 0,  1'b0, 3,
                    {8'h83, 8'h12, 8'h34, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'hA5}};
        vecs[1] = '{11'h123, 16'hBEEF, 16, 1'b1, 3,
                    {8'hC6, 8'hBE, 8'hEF, 8'h00, 8'h00, 8'h00, 8'h10, 8'h01, 8'h23, 8'hA5}};
        vecs[2] = '{11'h7FF, 16'h0001, 5,  1'b1, 5,
                    {8'h59, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h05, 8'h07, 8'hFF, 8'hA5}};
        frozen  = {8'hD3, 8'hBE, 8'hEF, 8'h00, 8'h00, 8'h00, 8'h05, 8'h01, 8'h23, 8'hA5};

        repeat (3) @(negedge clk);
        check("rst_cs", cs, 0);
        check("rst_w_r", w_r, 0);
        check("rst_grant", grant, 1);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_addr", addr, 0);
        check("rst_wdata", wdata, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Vector 0 has no clear and no counting, so it also checks the reset counter value.
        for (int v = 0; v < 3; v++) begin
            if (vecs[v].clr) begin
                @(negedge clk) cnt_clr = 1'b1;
                @(negedge clk) cnt_clr = 1'b0;
            end
            if (vecs[v].cyc > 0) begin
                @(negedge clk) cpu_en = 1'b1;
                repeat (vecs[v].cyc) @(negedge clk);
                cpu_en = 1'b0;
            end
            pc = vecs[v].pc;
            acc = vecs[v].acc;
            done_after = vecs[v].poll;
            base = cap.size();
            d0 = done_cnt;
            start_frame();
            check($sformatf("v%0d_busy", v), busy, 1);
            check($sformatf("v%0d_grant_low", v), grant, 0);
            wait_idle(0, $sformatf("v%0d_idle", v));
            check($sformatf("v%0d_nbytes", v), cap.size() - base, NB);
            for (int j = 0; j < NB; j++)
                check($sformatf("v%0d_byte%0d", v, j), cap_at(base + j), vecs[v].exp[j]);
            check($sformatf("v%0d_done", v), done_cnt - d0, 1);
            check($sformatf("v%0d_err", v), err, 0);
            check($sformatf("v%0d_grant", v), grant, 1);
        end

        // tx_done never rises: one read issue plus POLL_LIMIT polls, then abort.
        done_after = 100000;
        base = cap.size();
        d0 = done_cnt;
        r0 = rd_cycles;
        start_frame();
        wait_idle(0, "to_idle");
        check("to_read_cycles", rd_cycles - r0, 9);
        check("to_err", err, 1);
        check("to_no_done", done_cnt - d0, 0);
        check("to_nbytes", cap.size() - base, 1);
        check("to_last_waddr", last_waddr, 2);
        check("to_last_wdata", last_wdata, 0);
        check("to_grant", grant, 1);
        repeat (3) @(negedge clk);
        check("to_err_sticky", err, 1);
        done_after = 3;
        start_frame();
        check("err_cleared_on_start", err, 0);
        wait_idle(0, "err_clr_idle");

        // Snapshot frozen, mid-frame start ignored, start during the done cycle ignored.
        pc = 11'h123;
        acc = 16'hBEEF;
        done_after = 2;
        base = cap.size();
        d0 = done_cnt;
        start_frame();
        pc = 11'h7FF;
        acc = 16'h0000;
        cpu_en = 1'b1;
        repeat (3) @(negedge clk);
        start = 1'b1;
        @(negedge clk) start = 1'b0;
        wait_done("frz_done_seen");
        start = 1'b1;
        @(negedge clk) start = 1'b0;
        check("start_on_done_ignored", busy, 0);
        cpu_en = 1'b0;
        repeat (2) @(negedge clk);
        check("frz_still_idle", busy, 0);
        check("frz_nbytes", cap.size() - base, NB);
        for (int j = 0; j < NB; j++)
            check($sformatf("frz_byte%0d", j), cap_at(base + j), frozen[j]);
        check("frz_done", done_cnt - d0, 1);

        // Start on the first idle cycle after done is accepted.
        done_after = 3;
        start_frame();
        wait_done("fi_done_seen");
        @(negedge clk);
        check("fi_idle", busy, 0);
        start = 1'b1;
        @(negedge clk) start = 1'b0;
        check("start_first_idle", busy, 1);
        wait_idle(0, "fi_idle2");

        // 8-bit counter instance: 0xFF, wrap to 0, count, clear beats enable.
        @(negedge clk) en2 = 1'b1;
        repeat (255) @(negedge clk);
        en2 = 1'b0;
        frame8(8'hFF, "c8_ff");
        @(negedge clk) en2 = 1'b1;
        @(negedge clk) en2 = 1'b0;
        frame8(8'h00, "c8_wrap");
        @(negedge clk) en2 = 1'b1;
        repeat (5) @(negedge clk);
        en2 = 1'b0;
        frame8(8'h05, "c8_five");
        @(negedge clk) begin
            clr2 = 1'b1;
            en2 = 1'b1;
        end
        @(negedge clk) begin
            clr2 = 1'b0;
            en2 = 1'b0;
        end
        frame8(8'h00, "c8_clr_prio");

        // Asynchronous reset while polling tx_done.
        done_after = 4;
        base = cap.size();
        start_frame();
        for (int n = 0; n < 5000 && !(cs && !w_r && cap.size() - base >= 2); n++) @(negedge clk);
        check("mid_in_poll", cs && !w_r, 1);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_cs", cs, 0);
        check("mid_rst_grant", grant, 1);
        check("mid_rst_busy", busy, 0);
        @(negedge clk) rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("post_rst_busy", busy, 0);
        check("post_rst_cs", cs, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
